// File: rtl/mul_seq_ctrl.sv
// Shift-add multiply sequencer driving the AH/AL accumulator controls.
// Optional MUL_SEQ_STEP_EN adds a step input that gates exit from TEST.
module mul_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       al_lsb,
`ifdef MUL_SEQ_STEP_EN
  input  logic       step,
`endif
  output logic       ah_reset,
  output logic       ah_inen,
  output logic [1:0] hs,
  output logic [1:0] ls,
  output logic       alu_add,
  output logic       carry_clr,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHR  = 2'b01;
  localparam logic [1:0] SR_LOAD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_AH,
    XFER_AL,
    CLR_AH,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          adv;

`ifdef MUL_SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD_AH;
      LOAD_AH: state_nx = XFER_AL;
      XFER_AL: state_nx = CLR_AH;
      CLR_AH: begin
        count_nx = CW'(WIDTH);
        state_nx = TEST;
      end
      TEST: begin
        if (adv) state_nx = al_lsb ? ADD : SHIFT;
      end
      ADD:     state_nx = SHIFT;
      SHIFT: begin
        count_nx = count - CW'(1);
        // count still holds the pre-decrement value here
        state_nx = (count == CW'(1)) ? DONE : TEST;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ah_reset  = 1'b0;
    ah_inen   = 1'b0;
    hs        = SR_HOLD;
    ls        = SR_HOLD;
    alu_add   = 1'b0;
    carry_clr = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: ;
      LOAD_AH: begin
        ah_inen = 1'b1;
        hs      = SR_LOAD;
      end
      XFER_AL: ls = SR_LOAD;
      CLR_AH: begin
        ah_reset  = 1'b1;
        carry_clr = 1'b1;
      end
      TEST: ;
      ADD: begin
        alu_add = 1'b1;
        hs      = SR_LOAD;
      end
      SHIFT: begin
        hs        = SR_SHR;
        ls        = SR_SHR;
        carry_clr = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl with an accumulator/ALU/carry model.
// Build with MUL_SEQ_STEP_EN to exercise single-step waits in TEST.
module tb_mul_seq_ctrl;

  localparam int W = 4;
`ifdef MUL_SEQ_STEP_EN
  localparam int STEP_WAIT = 5;
`else
  localparam int STEP_WAIT = 0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       al_lsb;
  logic       ah_reset;
  logic       ah_inen;
  logic [1:0] hs;
  logic [1:0] ls;
  logic       alu_add;
  logic       carry_clr;
  logic       busy;
  logic       done;
`ifdef MUL_SEQ_STEP_EN
  logic       step = 1'b0;
  int         wcnt = 0;
`endif

  logic [3:0] ah = '0;
  logic [3:0] al = '0;
  logic       carry = 1'b0;
  logic [3:0] ah_in = '0;
  logic [3:0] mcand = '0;
  logic [4:0] sum;
  logic [3:0] alu_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] prod;
    int         lat;
    int         adds;
  } exp_t;
  exp_t sb[$];

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .al_lsb   (al_lsb),
`ifdef MUL_SEQ_STEP_EN
    .step     (step),
`endif
    .ah_reset (ah_reset),
    .ah_inen  (ah_inen),
    .hs       (hs),
    .ls       (ls),
    .alu_add  (alu_add),
    .carry_clr(carry_clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Accumulator datapath model
  assign sum    = {1'b0, ah} + {1'b0, mcand};
  assign alu_y  = alu_add ? sum[3:0] : ah;
  assign al_lsb = al[0];

  always @(posedge clk) begin
    if (ah_reset) ah <= '0;
    else begin
      case (hs)
        2'b11:   ah <= ah_inen ? ah_in : alu_y;
        2'b01:   ah <= {carry, ah[3:1]};
        2'b10:   ah <= {ah[2:0], 1'b0};
        default: ;
      endcase
    end
    case (ls)
      2'b11:   al <= ah;
      2'b01:   al <= {ah[0], al[3:1]};
      2'b10:   al <= {al[2:0], 1'b0};
      default: ;
    endcase
    if (carry_clr) carry <= 1'b0;
    else if (alu_add) carry <= sum[4];
  end

`ifdef MUL_SEQ_STEP_EN
  // TEST is the only busy state with every control at rest
  always @(negedge clk) begin
    if (busy && !done && !ah_reset && !ah_inen && hs == 2'b00 &&
        ls == 2'b00 && !alu_add && !carry_clr) begin
      if (wcnt == STEP_WAIT) begin
        step = 1'b1;
        wcnt = 0;
      end else begin
        step = 1'b0;
        wcnt = wcnt + 1;
      end
    end else begin
      step = 1'b0;
      wcnt = 0;
    end
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_ctrl(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_hsls"}, {28'd0, hs, ls}, 0);
    chk({tag, "_ctl"},
        {28'd0, ah_reset, ah_inen, alu_add, carry_clr}, 0);
  endtask

  task automatic start_op(input logic [3:0] mult, input logic [3:0] mc);
    exp_t e;
    ah_in  = mult;
    mcand  = mc;
    e.prod = 8'(mult) * 8'(mc);
    e.adds = $countones(mult);
    e.lat  = 3 + 2 * W + e.adds + STEP_WAIT * W;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle 0; poke drives a stray start
  task automatic wait_done(input string tag, input int poke);
    int   cyc = 0;
    int   adds = 0;
    int   bad = 0;
    bit   seen = 0;
    exp_t e;
    while (cyc < 400) begin
      if (alu_add) adds++;
      if (ah_inen && alu_add) bad++;
      start = (cyc == poke);
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_timeout"}, 32'(seen), 1);
    if (seen) begin
      chk({tag, "_lat"}, cyc, e.lat);
      chk({tag, "_prod"}, {24'd0, ah, al}, {24'd0, e.prod});
      chk({tag, "_adds"}, adds, e.adds);
      chk({tag, "_excl"}, bad, 0);
    end
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    clr   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_idle_ctrl("rst1");
    @(negedge clk);
    chk_idle_ctrl("rst2");
    clr = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 1);
    start = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("rst_drain", 32'(busy), 0);

    start_op(4'h3, 4'h5);
    wait_done("m3x5", -1);

    start_op(4'hF, 4'hF);
    wait_done("mFxF", -1);

    start_op(4'h0, 4'h9);
    wait_done("m0x9", 5);

    // Abort a run with clr in cycle 6
    start_op(4'hF, 4'hF);
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk_idle_ctrl("abort");
    clr = 1'b0;
    void'(sb.pop_back());

    start_op(4'h2, 4'h7);
    wait_done("m2x7", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Control sequencer for the 4-bit accumulator datapath: the AH/AL shift-register pair, its input mux and the carry flip-flop.
- Runs an unsigned shift-add multiply by driving the accumulator's load, shift, clear and mux controls.
- Inputs: the accumulator's AL LSB feedback and a start request. Outputs: every accumulator control strobe, plus busy/done status to the CPU top level.
- Result stays in AH:AL; multiplicand is supplied externally to the ALU B input.

Parameters:
- WIDTH, 4, operand width in bits; sets the iteration count. Iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- start  input  1  begin multiply; sampled only in IDLE
- al_lsb  input  1  AL bit 0 from the accumulator
- ah_reset  output  1  clear AH on the next edge
- ah_inen  output  1  AH input mux select: 1 = external operand, 0 = ALU result
- hs  output  2  AH shift-register control
- ls  output  2  AL shift-register control
- alu_add  output  1  1 = ALU computes AH+multiplicand and the carry FF captures carry; 0 = ALU passes AH, carry FF holds
- carry_clr  output  1  synchronous clear of the external carry FF
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Shift-register control encoding (hs/ls): 00 hold, 01 shift right (MSB in from carry_msb), 10 shift left, 11 parallel load.
- All outputs are Moore decodes of the registered state. clr forces state IDLE and count=0, giving outputs ah_reset=0, ah_inen=0, hs=00, ls=00, alu_add=0, carry_clr=0, busy=0, done=0.
- IDLE: all outputs inactive. start=1 -> LOAD_AH.
- LOAD_AH: ah_inen=1, hs=11 (multiplier loaded into AH from ah_in) -> XFER_AL.
- XFER_AL: ls=11 (AL loaded from AH) -> CLR_AH.
- CLR_AH: ah_reset=1, carry_clr=1; count loaded with WIDTH -> TEST.
- TEST: all controls hold. al_lsb=1 -> ADD; al_lsb=0 -> SHIFT.
- ADD: alu_add=1, ah_inen=0, hs=11 (AH <= AH+M, carry captured) -> SHIFT.
- SHIFT: hs=01, ls=01, carry_clr=1, count decremented.
  - Same-edge semantics: AH shifts in the old carry, AL shifts in the old AH[0], carry clears.
  - Decremented count==0 -> DONE; otherwise -> TEST.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- Latency:
  - Cycle 0 is the first cycle after the edge that samples start.
  - done is high in cycle 3 + 2*WIDTH + popcount(multiplier).
  - WIDTH=4: 11 cycles for multiplier 0x0, 15 for 0xF.
- Boundary conditions:
  - start while busy=1 is ignored; no queuing.
  - start held high through DONE starts a new operation from the IDLE cycle after DONE.
  - clr mid-operation returns to IDLE at that edge; AH:AL contents are undefined to software. Only control outputs are guaranteed.
  - clr and start in the same cycle: clr wins.
  - Multiplier 0: no ADD states; result 0.
- Never asserts ah_inen together with alu_add. Never asserts hs=11 and hs=01 in the same cycle (one-hot check per state).

Optional Feature:
- Macro: MUL_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit), placed after al_lsb.
  - FSM leaves TEST only in a cycle where step=1; step is ignored in every other state.
  - Used for single-step debug of the datapath.
  - Latency grows by the number of cycles spent waiting in TEST.
- Not defined: no step port; TEST always advances in one cycle, exactly as specified above.

Test Plan:
- Reset: clr=1 for 2 cycles, then start=1 -> busy=0, done=0, hs=ls=00 during clr; busy=1 the cycle after clr deasserts with start=1.
- Multiply 0x3 x 0x5: multiplier 0x3 on ah_in, M=0x5, start 1 cycle (bench includes accumulator, carry FF and ALU model) -> done in cycle 13, AH=0x0, AL=0xF, exactly 2 ADD states.
- Multiply 0xF x 0xF -> done in cycle 15, AH=0xE, AL=0x1; carry shifted into AH MSB on each SHIFT.
- Multiply 0x0 x 0x9 -> done in cycle 11, AH:AL=0x00, alu_add never asserted.
- clr asserted in cycle 6 of a 0xF x 0xF run -> next cycle busy=0 and all controls inactive. A following start of 0x2 x 0x7 gives AH:AL=0x0E in cycle 12.
- With MUL_SEQ_STEP_EN: 0x3 x 0x5 with step held 0 for 5 cycles in each TEST visit -> FSM stays in TEST with controls at hold; final AH:AL=0x0F, done delayed by 20 cycles (4 TEST visits x 5).
